izh_neuron_scheduler: RTL and testbench

//  Time-multiplexes one shared Izhikevich update core across N_NEURONS neurons.
//  - Holds each neuron's v/u state in internal registers.
//  - Every TICK_DIV clocks, sweeps the neurons in ascending index order:

---
 rtl/izh_neuron_scheduler.sv | 163 ++++++++++++++++
 tb/tb_izh_neuron_scheduler.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/izh_neuron_scheduler.sv
// Time-multiplexes one Izhikevich update core over N_NEURONS v/u states, one sweep per tick.
// Tick to sweep_done is N_NEURONS*(L+2)+1 cycles; stalls on core_done, and ticks arriving mid-sweep are dropped and flagged.
module izh_neuron_scheduler #(
    parameter int                     N_NEURONS = 8,
    parameter int                     IDX_W     = 3,
    parameter int                     DW        = 18,
    parameter int                     TICK_DIV  = 4096,
    parameter logic signed [DW-1:0]   V_RST     = -18'sd42598,
    parameter logic signed [DW-1:0]   U_RST     = 18'sd13107
) (
    input  logic                   CLOCK_50,
    input  logic                   reset,
    input  logic                   enable,
    output logic [IDX_W-1:0]       cur_idx,
    input  logic signed [DW-1:0]   I_in,
    output logic                   core_start,
    output logic signed [DW-1:0]   core_v,
    output logic signed [DW-1:0]   core_u,
    output logic signed [DW-1:0]   core_I,
    input  logic                   core_done,
    input  logic signed [DW-1:0]   core_vnew,
    input  logic signed [DW-1:0]   core_unew,
    input  logic                   core_spike,
    output logic [N_NEURONS-1:0]   spike_vec,
    output logic                   sweep_done,
    output logic                   busy,
    output logic                   overrun
);

    localparam int                 CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0]   TICK_LAST = CNT_W'(TICK_DIV - 1);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(N_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_DONE
    } state_t;

    state_t                 state;
    state_t                 state_nxt;
    logic [CNT_W-1:0]       tick_cnt;
    logic                   tick;
    logic signed [DW-1:0]   v_mem [N_NEURONS];
    logic signed [DW-1:0]   u_mem [N_NEURONS];
    logic signed [DW-1:0]   vnew_q;
    logic signed [DW-1:0]   unew_q;
    logic                   spike_q;
    logic [N_NEURONS-1:0]   acc;

    assign tick = (tick_cnt == TICK_LAST);

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        core_start = 1'b0;
        sweep_done = 1'b0;
        busy       = 1'b1;
        case (state)
            S_IDLE: begin
                busy = 1'b0;
                if (tick && enable) begin
                    state_nxt = S_ISSUE;
                end
            end
            S_ISSUE: begin
                core_start = 1'b1;
                state_nxt  = S_WAIT;
            end
            S_WAIT: begin
                if (core_done) begin
                    state_nxt = S_WRITE;
                end
            end
            S_WRITE: begin
                state_nxt = (cur_idx == IDX_LAST) ? S_DONE : S_ISSUE;
            end
            S_DONE: begin
                sweep_done = 1'b1;
                state_nxt  = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // core_done is only honoured in WAIT, so stray or late results never reach the state arrays
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            cur_idx   <= '0;
            core_v    <= '0;
            core_u    <= '0;
            core_I    <= '0;
            vnew_q    <= '0;
            unew_q    <= '0;
            spike_q   <= 1'b0;
            acc       <= '0;
            spike_vec <= '0;
            overrun   <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_RST;
                u_mem[i] <= U_RST;
            end
        end else begin
            if (tick && busy) begin
                overrun <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (tick && enable) begin
                        cur_idx <= '0;
                        acc     <= '0;
                    end
                end
                S_ISSUE: begin
                    core_v <= v_mem[cur_idx];
                    core_u <= u_mem[cur_idx];
                    core_I <= I_in;
                end
                S_WAIT: begin
                    if (core_done) begin
                        vnew_q  <= core_vnew;
                        unew_q  <= core_unew;
                        spike_q <= core_spike;
                    end
                end
                S_WRITE: begin
                    v_mem[cur_idx] <= vnew_q;
                    u_mem[cur_idx] <= unew_q;
                    acc[cur_idx]   <= spike_q;
                    if (cur_idx != IDX_LAST) begin
                        cur_idx <= cur_idx + 1'b1;
                    end
                end
                S_DONE: begin
                    spike_vec <= acc;
                    cur_idx   <= '0;
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_izh_neuron_scheduler.sv
// Directed bench for izh_neuron_scheduler: mock update core with programmable latency,
// per-scenario tasks comparing observed sweeps against a small v/u model.
module tb_izh_neuron_scheduler;

    localparam int                N  = 8;
    localparam int                TD = 64;
    localparam logic signed [17:0] V_RST = -18'sd42598;
    localparam logic signed [17:0] U_RST = 18'sd13107;

    logic                CLOCK_50 = 1'b0;
    logic                reset;
    logic                enable;
    logic [2:0]          cur_idx;
    logic signed [17:0]  I_in;
    logic                core_start;
    logic signed [17:0]  core_v;
    logic signed [17:0]  core_u;
    logic signed [17:0]  core_I;
    logic                core_done;
    logic signed [17:0]  core_vnew;
    logic signed [17:0]  core_unew;
    logic                core_spike;
    logic [7:0]          spike_vec;
    logic                sweep_done;
    logic                busy;
    logic                overrun;

    int checks = 0;
    int errors = 0;

    always #10 CLOCK_50 = ~CLOCK_50;

    izh_neuron_scheduler #(
        .N_NEURONS(N), .IDX_W(3), .DW(18), .TICK_DIV(TD), .V_RST(V_RST), .U_RST(U_RST)
    ) dut (
        .CLOCK_50(CLOCK_50), .reset(reset), .enable(enable), .cur_idx(cur_idx), .I_in(I_in),
        .core_start(core_start), .core_v(core_v), .core_u(core_u), .core_I(core_I),
        .core_done(core_done), .core_vnew(core_vnew), .core_unew(core_unew),
        .core_spike(core_spike), .spike_vec(spike_vec), .sweep_done(sweep_done),
        .busy(busy), .overrun(overrun)
    );

    // Mock update core: result L=lat cycles after core_start, v+1 / u+2, spike from mask
    int                 lat = 3;
    int                 mk_cnt;
    logic               mk_done;
    logic               xtra_done = 1'b0;
    logic [7:0]         spike_mask = 8'h00;
    logic signed [17:0] i_base = -18'sd50000;

    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            mk_cnt <= 0; mk_done <= 1'b0;
        end else if (core_start) begin
            mk_cnt <= lat - 1; mk_done <= (lat == 1);
        end else if (mk_cnt > 0) begin
            mk_cnt <= mk_cnt - 1; mk_done <= (mk_cnt == 1);
        end else begin
            mk_done <= 1'b0;
        end
    end

    assign core_done  = mk_done | xtra_done;
    assign core_vnew  = core_v + 18'sd1;
    assign core_unew  = core_u + 18'sd2;
    assign core_spike = spike_mask[cur_idx];
    assign I_in       = 18'(int'(i_base) + int'(cur_idx) * 3000);

    // Reference tick counter and free cycle stamp
    int tb_cnt;
    int gcyc = 0;
    always @(posedge CLOCK_50 or posedge reset) begin
        if (reset) tb_cnt <= 0;
        else       tb_cnt <= (tb_cnt == TD - 1) ? 0 : tb_cnt + 1;
    end
    always @(posedge CLOCK_50) gcyc <= gcyc + 1;

    logic signed [17:0] exp_v [N];
    logic signed [17:0] exp_u [N];
    logic signed [17:0] obs_v [N];
    logic signed [17:0] obs_u [N];
    logic signed [17:0] obs_I [N];
    int                 sw_starts;
    int                 sw_done_cyc;
    bit                 sw_ord_ok;
    logic [7:0]         sw_pre_spk;
    logic [7:0]         sw_spk;

    task automatic model_reset;
        for (int i = 0; i < N; i++) begin exp_v[i] = V_RST; exp_u[i] = U_RST; end
    endtask

    task automatic model_step;
        for (int i = 0; i < N; i++) begin exp_v[i] = exp_v[i] + 18'sd1; exp_u[i] = exp_u[i] + 18'sd2; end
    endtask

    task automatic wait_tick(output int tcyc);
        tcyc = -1000;
        for (int k = 0; k < 3 * TD; k++) begin
            @(negedge CLOCK_50);
            if (tb_cnt == TD - 1) begin tcyc = gcyc; break; end
        end
    endtask

    task automatic run_sweep(input int drop_at);
        bit         pend;
        logic [2:0] pidx;
        pend = 0; pidx = '0; sw_starts = 0; sw_done_cyc = -1; sw_ord_ok = 1;
        sw_pre_spk = 'x; sw_spk = 'x;
        for (int k = 0; k < 200; k++) begin
            @(negedge CLOCK_50);
            if (pend) begin obs_v[pidx] = core_v; obs_u[pidx] = core_u; obs_I[pidx] = core_I; pend = 0; end
            if (core_start) begin
                if (sw_starts >= N || cur_idx != 3'(sw_starts)) sw_ord_ok = 0;
                sw_starts++; pidx = cur_idx; pend = 1;
                if (drop_at == int'(cur_idx)) enable = 1'b0;
            end
            if (sweep_done) begin
                sw_done_cyc = gcyc; sw_pre_spk = spike_vec;
                @(negedge CLOCK_50);
                sw_spk = spike_vec;
                break;
            end
        end
    endtask

    task automatic test_reset;
        reset = 1'b1; enable = 1'b0;
        repeat (3) @(negedge CLOCK_50);
        reset = 1'b0;
        repeat (20) @(negedge CLOCK_50);
        #3 reset = 1'b1;
        #1;
        checks++; if (spike_vec !== 8'h00) begin errors++; $display("FAIL reset_spike_vec: got %h want 00", spike_vec); end
        checks++; if (sweep_done !== 1'b0) begin errors++; $display("FAIL reset_sweep_done: got %b want 0", sweep_done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        checks++; if (core_start !== 1'b0) begin errors++; $display("FAIL reset_core_start: got %b want 0", core_start); end
        checks++; if (cur_idx !== 3'd0) begin errors++; $display("FAIL reset_cur_idx: got %0d want 0", cur_idx); end
        checks++; if (core_v !== 18'sd0) begin errors++; $display("FAIL reset_core_v: got %0d want 0", core_v); end
        checks++; if (core_u !== 18'sd0) begin errors++; $display("FAIL reset_core_u: got %0d want 0", core_u); end
        checks++; if (core_I !== 18'sd0) begin errors++; $display("FAIL reset_core_I: got %0d want 0", core_I); end
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_single_sweep;
        int t;
        logic signed [17:0] ei;
        lat = 3; spike_mask = 8'h00; enable = 1'b1;
        wait_tick(t);
        run_sweep(-1);
        checks++; if (sw_starts !== 8) begin errors++; $display("FAIL single_starts: got %0d want 8", sw_starts); end
        checks++; if (sw_done_cyc - t !== 41) begin errors++; $display("FAIL single_latency: got %0d want 41", sw_done_cyc - t); end
        checks++; if (sw_ord_ok !== 1'b1) begin errors++; $display("FAIL single_order: got %b want 1", sw_ord_ok); end
        for (int i = 0; i < N; i++) begin
            ei = 18'(int'(i_base) + i * 3000);
            checks++; if (obs_v[i] !== exp_v[i]) begin errors++; $display("FAIL single_v[%0d]: got %0d want %0d", i, obs_v[i], exp_v[i]); end
            checks++; if (obs_u[i] !== exp_u[i]) begin errors++; $display("FAIL single_u[%0d]: got %0d want %0d", i, obs_u[i], exp_u[i]); end
            checks++; if (obs_I[i] !== ei) begin errors++; $display("FAIL single_I[%0d]: got %0d want %0d", i, obs_I[i], ei); end
        end
        checks++; if (sw_spk !== 8'h00) begin errors++; $display("FAIL single_spike_vec: got %h want 00", sw_spk); end
        model_step();
        wait_tick(t);
        run_sweep(-1);
        for (int i = 0; i < N; i++) begin
            checks++; if (obs_v[i] !== exp_v[i]) begin errors++; $display("FAIL second_v[%0d]: got %0d want %0d", i, obs_v[i], exp_v[i]); end
            checks++; if (obs_u[i] !== exp_u[i]) begin errors++; $display("FAIL second_u[%0d]: got %0d want %0d", i, obs_u[i], exp_u[i]); end
        end
        model_step();
    endtask

    task automatic test_spikes;
        int t;
        spike_mask = 8'b1000_1001;
        wait_tick(t);
        run_sweep(-1);
        checks++; if (sw_starts !== 8) begin errors++; $display("FAIL spikes_starts: got %0d want 8", sw_starts); end
        checks++; if (sw_pre_spk !== 8'h00) begin errors++; $display("FAIL spikes_pre: got %h want 00", sw_pre_spk); end
        checks++; if (sw_spk !== 8'h89) begin errors++; $display("FAIL spikes_vec: got %h want 89", sw_spk); end
        model_step();
        spike_mask = 8'h00;
        wait_tick(t);
        checks++; if (spike_vec !== 8'h89) begin errors++; $display("FAIL spikes_hold_idle: got %h want 89", spike_vec); end
        run_sweep(-1);
        checks++; if (sw_pre_spk !== 8'h89) begin errors++; $display("FAIL spikes_hold: got %h want 89", sw_pre_spk); end
        checks++; if (sw_spk !== 8'h00) begin errors++; $display("FAIL spikes_clear: got %h want 00", sw_spk); end
        model_step();
    endtask

    task automatic test_overrun;
        int t;
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_pre: got %b want 0", overrun); end
        lat = 7;
        for (int s = 0; s < 2; s++) begin
            wait_tick(t);
            run_sweep(-1);
            checks++; if (sw_starts !== 8) begin errors++; $display("FAIL overrun_starts%0d: got %0d want 8", s, sw_starts); end
            checks++; if (sw_done_cyc - t !== 73) begin errors++; $display("FAIL overrun_latency%0d: got %0d want 73", s, sw_done_cyc - t); end
            checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag%0d: got %b want 1", s, overrun); end
            for (int i = 0; i < N; i++) begin
                checks++; if (obs_v[i] !== exp_v[i]) begin errors++; $display("FAIL overrun_v%0d[%0d]: got %0d want %0d", s, i, obs_v[i], exp_v[i]); end
            end
            model_step();
        end
        lat = 3;
    endtask

    task automatic test_enable_drop;
        int t;
        int n_busy;
        wait_tick(t);
        run_sweep(4);
        checks++; if (sw_starts !== 8) begin errors++; $display("FAIL drop_starts: got %0d want 8", sw_starts); end
        checks++; if (sw_done_cyc - t !== 41) begin errors++; $display("FAIL drop_latency: got %0d want 41", sw_done_cyc - t); end
        model_step();
        n_busy = 0;
        for (int k = 0; k < 3 * TD; k++) begin
            @(negedge CLOCK_50);
            if (busy || core_start) n_busy++;
        end
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL drop_idle: got %0d busy cycles want 0", n_busy); end
        wait_tick(t);
        repeat (10) @(negedge CLOCK_50);
        enable = 1'b1;
        n_busy = 0;
        for (int k = 0; k < TD && tb_cnt != TD - 1; k++) begin
            if (busy || core_start) n_busy++;
            @(negedge CLOCK_50);
        end
        t = gcyc;
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL rise_midperiod: got %0d busy cycles want 0", n_busy); end
        run_sweep(-1);
        checks++; if (sw_done_cyc - t !== 41) begin errors++; $display("FAIL rise_latency: got %0d want 41", sw_done_cyc - t); end
        model_step();
    endtask

    task automatic test_min_latency;
        int t;
        lat = 1; spike_mask = 8'hFF;
        wait_tick(t);
        run_sweep(-1);
        checks++; if (sw_done_cyc - t !== 25) begin errors++; $display("FAIL l1_latency: got %0d want 25", sw_done_cyc - t); end
        checks++; if (sw_spk !== 8'hFF) begin errors++; $display("FAIL l1_spike_vec: got %h want ff", sw_spk); end
        for (int i = 0; i < N; i++) begin
            checks++; if (obs_v[i] !== exp_v[i]) begin errors++; $display("FAIL l1_v[%0d]: got %0d want %0d", i, obs_v[i], exp_v[i]); end
        end
        model_step();
        spike_mask = 8'h00;
    endtask

    task automatic test_reset_in_wait;
        int  t;
        int  n_busy;
        bit  found;
        lat = 5;
        wait_tick(t);
        found = 0;
        for (int k = 0; k < 100 && !found; k++) begin
            @(negedge CLOCK_50);
            if (core_start && cur_idx == 3'd5) found = 1;
        end
        checks++; if (found !== 1'b1) begin errors++; $display("FAIL rst_reach_n5: got %b want 1", found); end
        @(negedge CLOCK_50);
        checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL rst_overrun_sticky: got %b want 1", overrun); end
        #2 reset = 1'b1;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b want 0", busy); end
        checks++; if (cur_idx !== 3'd0) begin errors++; $display("FAIL rst_cur_idx: got %0d want 0", cur_idx); end
        checks++; if (spike_vec !== 8'h00) begin errors++; $display("FAIL rst_spike_vec: got %h want 00", spike_vec); end
        checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun: got %b want 0", overrun); end
        checks++; if (core_v !== 18'sd0) begin errors++; $display("FAIL rst_core_v: got %0d want 0", core_v); end
        @(negedge CLOCK_50);
        reset = 1'b0;
        model_reset();
        xtra_done = 1'b1;
        n_busy = 0;
        repeat (4) begin
            @(negedge CLOCK_50);
            if (busy || sweep_done) n_busy++;
        end
        xtra_done = 1'b0;
        checks++; if (n_busy !== 0) begin errors++; $display("FAIL rst_late_done: got %0d active cycles want 0", n_busy); end
        lat = 3;
        wait_tick(t);
        run_sweep(-1);
        checks++; if (sw_starts !== 8) begin errors++; $display("FAIL rst_starts: got %0d want 8", sw_starts); end
        for (int i = 0; i < N; i++) begin
            checks++; if (obs_v[i] !== exp_v[i]) begin errors++; $display("FAIL rst_v[%0d]: got %0d want %0d", i, obs_v[i], exp_v[i]); end
            checks++; if (obs_u[i] !== exp_u[i]) begin errors++; $display("FAIL rst_u[%0d]: got %0d want %0d", i, obs_u[i], exp_u[i]); end
        end
        model_step();
    endtask

    initial begin
        test_reset();
        test_single_sweep();
        test_spikes();
        test_overrun();
        test_enable_drop();
        test_min_latency();
        test_reset_in_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
